imem_load_ctrl: RTL and testbench

Sequencing controller for the RISC-V core under test. It owns the instruction-memory and data-memory init ports during program load and holds the core stalled until started. It hands the instruction-memory port to core fetch while the program runs. After the core halts (or a run timeout expires) it drains the pipeline and streams all architectural registers out through register-file read port 1 for checking.

---
 rtl/imem_load_ctrl_if.sv | 50 +++++
 rtl/imem_load_ctrl.sv | 177 +++++++++++++++++
 tb/tb_imem_load_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_load_ctrl_if.sv
// Signal bundle between the load/run/dump sequencer and its surroundings:
// program loader, core fetch/halt, memory init ports, register file and dump sink.
interface imem_load_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              ld_valid;
  logic              ld_ready;
  logic              ld_sel;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              start;
  logic              core_halt;
  logic [ADDR_W-1:0] fetch_pc;
  logic              core_stall;
  logic              imem_write;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              init_mem;
  logic [ADDR_W-1:0] init_addr;
  logic [DATA_W-1:0] init_data;
  logic [4:0]        rf_raddr1;
  logic [DATA_W-1:0] rf_rdata1;
  logic              dump_valid;
  logic              dump_ready;
  logic [4:0]        dump_idx;
  logic [DATA_W-1:0] dump_data;
  logic [15:0]       load_count;
  logic              align_err;
  logic              timeout;
  logic [2:0]        state;

  // Controller side
  modport slave (
    input  ld_valid, ld_sel, ld_addr, ld_data, start, core_halt, fetch_pc,
           rf_rdata1, dump_ready,
    output ld_ready, core_stall, imem_write, imem_addr, imem_wdata,
           init_mem, init_addr, init_data, rf_raddr1, dump_valid, dump_idx,
           dump_data, load_count, align_err, timeout, state
  );

  // Harness / loader side
  modport master (
    output ld_valid, ld_sel, ld_addr, ld_data, start, core_halt, fetch_pc,
           rf_rdata1, dump_ready,
    input  ld_ready, core_stall, imem_write, imem_addr, imem_wdata,
           init_mem, init_addr, init_data, rf_raddr1, dump_valid, dump_idx,
           dump_data, load_count, align_err, timeout, state
  );
endinterface

// File: rtl/imem_load_ctrl.sv
// Program-load / run / drain / register-dump sequencer for the core under test.
// The bus interface instance must use the same ADDR_W/DATA_W as this module.
module imem_load_ctrl #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned NREGS          = 32,
  parameter int unsigned DRAIN_CYCLES   = 4,
  parameter int unsigned MAX_RUN_CYCLES = 0
) (
  input logic             clk,
  input logic             reset,
  imem_load_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DUMP  = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic              rdy_en_q;
  logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
  logic [DATA_W-1:0] ld_data_q, ld_data_d;
  logic              imem_write_q, imem_write_d;
  logic              init_mem_q, init_mem_d;
  logic [15:0]       load_count_q, load_count_d;
  logic              align_err_q, align_err_d;
  logic              timeout_q, timeout_d;
  logic              core_stall_q, core_stall_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [4:0]        idx_q, idx_d;
  logic              dump_valid_q, dump_valid_d;
  logic [4:0]        dump_idx_q, dump_idx_d;
  logic [DATA_W-1:0] dump_data_q, dump_data_d;
  logic              ld_ready;
  logic              ld_hs;

  // rdy_en_q keeps the loader closed until the first clock after reset release.
  assign ld_ready = (state_q == S_IDLE) && rdy_en_q;
  assign ld_hs    = bus.ld_valid && ld_ready;

  always_comb begin
    state_d      = state_q;
    ld_addr_d    = ld_addr_q;
    ld_data_d    = ld_data_q;
    imem_write_d = 1'b0;
    init_mem_d   = 1'b0;
    load_count_d = load_count_q;
    align_err_d  = align_err_q;
    timeout_d    = timeout_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    dump_valid_d = dump_valid_q;
    dump_idx_d   = dump_idx_q;
    dump_data_d  = dump_data_q;

    if (ld_hs) begin
      ld_addr_d = bus.ld_addr;
      ld_data_d = bus.ld_data;
      if (bus.ld_addr[1:0] != 2'b00) begin
        align_err_d = 1'b1;
      end else begin
        imem_write_d = !bus.ld_sel;
        init_mem_d   = bus.ld_sel;
        if (load_count_q != 16'hFFFF) load_count_d = load_count_q + 16'd1;
      end
    end

    case (state_q)
      S_IDLE: if (bus.start) state_d = S_ARM;
      S_ARM: begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
      S_RUN: begin
        cnt_d = cnt_q + 32'd1;
        if (bus.core_halt) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else if (MAX_RUN_CYCLES != 0 && cnt_q == MAX_RUN_CYCLES - 1) begin
          timeout_d = 1'b1;
          state_d   = S_DRAIN;
          cnt_d     = '0;
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == DRAIN_CYCLES - 1) begin
          state_d = S_DUMP;
          idx_d   = '0;
        end
      end
      S_DUMP: begin
        // Invalid cycle = register-file read slot; valid cycle = offer until taken.
        if (!dump_valid_q) begin
          dump_valid_d = 1'b1;
          dump_data_d  = bus.rf_rdata1;
          dump_idx_d   = idx_q;
        end else if (bus.dump_ready) begin
          dump_valid_d = 1'b0;
          if (idx_q == 5'(NREGS - 1)) state_d = S_DONE;
          else                        idx_d   = idx_q + 5'd1;
        end
      end
      S_DONE: begin
        if (bus.start) begin
          state_d      = S_IDLE;
          load_count_d = '0;
          align_err_d  = 1'b0;
          timeout_d    = 1'b0;
          dump_idx_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    core_stall_d = (state_d != S_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rdy_en_q     <= 1'b0;
      ld_addr_q    <= '0;
      ld_data_q    <= '0;
      imem_write_q <= 1'b0;
      init_mem_q   <= 1'b0;
      load_count_q <= '0;
      align_err_q  <= 1'b0;
      timeout_q    <= 1'b0;
      core_stall_q <= 1'b1;
      cnt_q        <= '0;
      idx_q        <= '0;
      dump_valid_q <= 1'b0;
      dump_idx_q   <= '0;
      dump_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      rdy_en_q     <= 1'b1;
      ld_addr_q    <= ld_addr_d;
      ld_data_q    <= ld_data_d;
      imem_write_q <= imem_write_d;
      init_mem_q   <= init_mem_d;
      load_count_q <= load_count_d;
      align_err_q  <= align_err_d;
      timeout_q    <= timeout_d;
      core_stall_q <= core_stall_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      dump_valid_q <= dump_valid_d;
      dump_idx_q   <= dump_idx_d;
      dump_data_q  <= dump_data_d;
    end
  end

  assign bus.ld_ready   = ld_ready;
  assign bus.core_stall = core_stall_q;
  assign bus.imem_write = imem_write_q;
  assign bus.imem_addr  = (state_q == S_RUN) ? bus.fetch_pc : ld_addr_q;
  assign bus.imem_wdata = ld_data_q;
  assign bus.init_mem   = init_mem_q;
  assign bus.init_addr  = ld_addr_q;
  assign bus.init_data  = ld_data_q;
  assign bus.rf_raddr1  = (state_q == S_DUMP) ? idx_q : '0;
  assign bus.dump_valid = dump_valid_q;
  assign bus.dump_idx   = dump_idx_q;
  assign bus.dump_data  = dump_data_q;
  assign bus.load_count = load_count_q;
  assign bus.align_err  = align_err_q;
  assign bus.timeout    = timeout_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed-plus-random bench for imem_load_ctrl: loads, start/run/halt/timeout,
// register dump against a model register file, and reset during dump.
module tb_imem_load_ctrl;
  localparam int unsigned NREGS = 32;
  localparam int unsigned DRAIN = 4;
  localparam int unsigned MAXRUN = 10;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_ARM = 3'd1, ST_RUN = 3'd2,
                         ST_DRAIN = 3'd3, ST_DUMP = 3'd4, ST_DONE = 3'd5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imem_load_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  imem_load_ctrl #(
    .ADDR_W(32), .DATA_W(32), .NREGS(NREGS),
    .DRAIN_CYCLES(DRAIN), .MAX_RUN_CYCLES(MAXRUN)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  logic [31:0] rf [NREGS];
  assign bus.rf_rdata1 = rf[bus.rf_raddr1];

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [15:0] m_count;
  logic        m_align;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic new_rf();
    for (int i = 0; i < NREGS; i++) rf[i] = $urandom;
  endtask

  // One load handshake in IDLE, optionally with start in the same cycle.
  task automatic load(input logic sel, input logic [31:0] addr, input logic [31:0] data,
                      input logic with_start);
    logic ok;
    bus.ld_valid = 1'b1;
    bus.ld_sel   = sel;
    bus.ld_addr  = addr;
    bus.ld_data  = data;
    bus.start    = with_start;
    chk("ld_ready", bus.ld_ready, 1'b1);
    step();
    bus.ld_valid = 1'b0;
    bus.start    = 1'b0;
    ok = (addr[1:0] == 2'b00);
    if (ok) begin
      if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
    end else m_align = 1'b1;
    chk("imem_write", bus.imem_write, ok && !sel);
    chk("init_mem", bus.init_mem, ok && sel);
    if (ok && !sel) begin
      chk("imem_addr", bus.imem_addr, addr);
      chk("imem_wdata", bus.imem_wdata, data);
    end
    if (ok && sel) begin
      chk("init_addr", bus.init_addr, addr);
      chk("init_data", bus.init_data, data);
    end
    chk("load_count", bus.load_count, m_count);
    chk("align_err", bus.align_err, m_align);
  endtask

  // Starting at an ARM observation, stay in RUN for run_cycles cycles, halting in the last one if asked.
  task automatic run_phase(input int unsigned run_cycles, input logic halt_last);
    chk("arm_state", bus.state, ST_ARM);
    chk("arm_stall", bus.core_stall, 1'b1);
    chk("arm_ready", bus.ld_ready, 1'b0);
    step();
    for (int unsigned c = 0; c < run_cycles; c++) begin
      bus.fetch_pc = $urandom & 32'hFFFF_FFFC;
      bus.start    = (c == 1);
      #1;
      chk("run_state", bus.state, ST_RUN);
      chk("run_stall", bus.core_stall, 1'b0);
      chk("run_fetch", bus.imem_addr, bus.fetch_pc);
      chk("run_nowrite", bus.imem_write, 1'b0);
      if (halt_last && c == run_cycles - 1) bus.core_halt = 1'b1;
      step();
      bus.core_halt = 1'b0;
      bus.start     = 1'b0;
    end
  endtask

  // Starting at the first DRAIN observation: drain, then dump the model register file.
  task automatic drain_dump(input logic rand_ready, input int unsigned stop_at,
                            input logic exp_timeout);
    int unsigned exp_i = 0;
    int unsigned cyc = 0;
    logic        held = 1'b0;
    logic [31:0] prev = '0;
    for (int unsigned c = 0; c < DRAIN; c++) begin
      chk("drain_state", bus.state, ST_DRAIN);
      chk("drain_stall", bus.core_stall, 1'b1);
      chk("drain_timeout", bus.timeout, exp_timeout);
      step();
    end
    chk("dump_entry_state", bus.state, ST_DUMP);
    chk("dump_entry_valid", bus.dump_valid, 1'b0);
    while (exp_i < NREGS && cyc < 600) begin
      if (bus.dump_valid && exp_i == stop_at) break;
      bus.dump_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (held) begin
        chk("dump_hold_valid", bus.dump_valid, 1'b1);
        chk("dump_hold_data", bus.dump_data, prev);
      end
      if (bus.dump_valid) begin
        chk("dump_idx", bus.dump_idx, 5'(exp_i));
        chk("dump_data", bus.dump_data, rf[exp_i]);
        if (bus.dump_ready) begin
          exp_i++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          prev = bus.dump_data;
        end
      end
      step();
      cyc++;
    end
    if (stop_at >= NREGS) begin
      chk("dump_count", exp_i, NREGS);
      if (!rand_ready) chk("dump_cycles", cyc, 64);
      chk("done_state", bus.state, ST_DONE);
      chk("done_valid", bus.dump_valid, 1'b0);
      chk("done_stall", bus.core_stall, 1'b1);
      chk("done_timeout", bus.timeout, exp_timeout);
      chk("done_count", bus.load_count, m_count);
    end else begin
      chk("dump_stop_reached", exp_i, stop_at);
    end
  endtask

  task automatic done_to_idle();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    m_count = '0;
    m_align = 1'b0;
    chk("restart_state", bus.state, ST_IDLE);
    chk("restart_count", bus.load_count, 16'd0);
    chk("restart_align", bus.align_err, 1'b0);
    chk("restart_timeout", bus.timeout, 1'b0);
    chk("restart_dump_idx", bus.dump_idx, 5'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus.ld_valid = 1'b1;
    bus.ld_sel = 1'b0;
    bus.ld_addr = 32'h40;
    bus.ld_data = 32'h1234_5678;
    bus.start = 1'b0;
    bus.core_halt = 1'b0;
    bus.fetch_pc = '0;
    bus.dump_ready = 1'b0;
    m_count = '0;
    m_align = 1'b0;
    new_rf();
    step();
    step();
    chk("rst_state", bus.state, ST_IDLE);
    chk("rst_stall", bus.core_stall, 1'b1);
    chk("rst_ready", bus.ld_ready, 1'b0);
    chk("rst_imem_write", bus.imem_write, 1'b0);
    chk("rst_init_mem", bus.init_mem, 1'b0);
    chk("rst_dump_valid", bus.dump_valid, 1'b0);
    chk("rst_dump_idx", bus.dump_idx, 5'd0);
    chk("rst_dump_data", bus.dump_data, 32'd0);
    chk("rst_count", bus.load_count, 16'd0);
    chk("rst_align", bus.align_err, 1'b0);
    chk("rst_timeout", bus.timeout, 1'b0);
    chk("rst_raddr", bus.rf_raddr1, 5'd0);
    bus.ld_valid = 1'b0;
    reset = 1'b0;
    step();
    step();

    // Directed back-to-back loads, then a misaligned one and a recovery load
    load(1'b0, 32'h0000_0000, 32'h0050_0093, 1'b0);
    load(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0);
    chk("two_loads_count", bus.load_count, 16'd2);
    load(1'b0, 32'h0000_0006, 32'hCAFE_F00D, 1'b0);
    load(1'b0, 32'h0000_0004, 32'h0000_0013, 1'b0);

    // Random loads with idle gaps
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a;
      a = $urandom & 32'h0000_FFFC;
      if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
      load(1'($urandom_range(0, 1)), a, $urandom, 1'b0);
      if ($urandom_range(0, 2) == 0) begin
        step();
        chk("gap_imem_write", bus.imem_write, 1'b0);
        chk("gap_init_mem", bus.init_mem, 1'b0);
      end
    end

    // Run 1: start with a same-cycle load, halt in RUN, full-rate dump
    load(1'b0, 32'h0000_0200, 32'h0000_006F, 1'b1);
    run_phase(4, 1'b1);
    drain_dump(1'b0, NREGS, 1'b0);
    done_to_idle();

    // Run 2: no halt, timeout after MAXRUN cycles, dump with dump_ready toggling
    new_rf();
    load(1'b1, 32'h0000_0300, $urandom, 1'b0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    run_phase(MAXRUN, 1'b0);
    chk("timeout_flag", bus.timeout, 1'b1);
    drain_dump(1'b1, NREGS, 1'b1);
    done_to_idle();

    // Run 3: halt on the last allowed cycle wins over timeout; reset mid-dump
    new_rf();
    load(1'b0, 32'h0000_0010, $urandom, 1'b0);
    load(1'b1, 32'h0000_0021, $urandom, 1'b0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    run_phase(MAXRUN, 1'b1);
    chk("halt_wins_timeout", bus.timeout, 1'b0);
    drain_dump(1'b0, 7, 1'b0);
    chk("pre_reset_idx", bus.dump_idx, 5'd7);
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_count = '0;
    m_align = 1'b0;
    chk("mid_rst_state", bus.state, ST_IDLE);
    chk("mid_rst_stall", bus.core_stall, 1'b1);
    chk("mid_rst_valid", bus.dump_valid, 1'b0);
    chk("mid_rst_idx", bus.dump_idx, 5'd0);
    chk("mid_rst_data", bus.dump_data, 32'd0);
    chk("mid_rst_count", bus.load_count, 16'd0);
    chk("mid_rst_align", bus.align_err, 1'b0);
    chk("mid_rst_timeout", bus.timeout, 1'b0);
    chk("mid_rst_raddr", bus.rf_raddr1, 5'd0);
    step();
    step();
    load(1'b1, 32'h0000_0400, 32'h0BAD_CAFE, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
